alu_ctl_seq: RTL and testbench

- Parametrised successor to the single-cycle ALU control decode: merges ALUOp/funct decoding with a registered ALU datapath and an iterative multiply/divide engine.
- Targets the multi-cycle MIPS core. Issues one operation per start pulse and reports completion with busy/done handshake, so the core stalls only on MUL/DIVU.

---
 rtl/alu_ctl_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_ctl_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctl_seq.sv
// ALU control decode merged with a registered single-cycle ALU and an
// iterative shift-add multiplier / restoring divider behind a start/busy/done handshake.
module alu_ctl_seq #(
  parameter int WIDTH   = 16,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic [3:0]         alu_ctl,
  output logic               zero,
  output logic               ovf,
  output logic               div_zero,
  output logic               illegal,
  output logic               busy,
  output logic               done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_AND  = 4'd2;
  localparam logic [3:0] C_OR   = 4'd3;
  localparam logic [3:0] C_SLT  = 4'd4;
  localparam logic [3:0] C_SLL  = 4'd5;
  localparam logic [3:0] C_SRL  = 4'd6;
  localparam logic [3:0] C_MUL  = 4'd8;
  localparam logic [3:0] C_DIVU = 4'd9;
  localparam logic [3:0] C_ILL  = 4'd15;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Upper funct bits beyond the decoded nibble must be zero for a legal R-type.
  function automatic logic [3:0] decode(input logic [1:0] op, input logic [FUNCT_W-1:0] fn);
    logic [3:0] c;
    c = C_ILL;
    case (op)
      2'b00: c = C_ADD;
      2'b01: c = C_SUB;
      2'b11: c = C_SLT;
      2'b10: begin
        if ((fn >> 4) != {FUNCT_W{1'b0}}) begin
          c = C_ILL;
        end else begin
          case (fn[3:0])
            4'b0000: c = C_ADD;
            4'b0001: c = C_SUB;
            4'b0010: c = C_AND;
            4'b0011: c = C_OR;
            4'b0100: c = C_SLT;
            4'b0101: c = C_SLL;
            4'b0110: c = C_SRL;
            4'b1000: c = C_MUL;
            4'b1001: c = C_DIVU;
            default: c = C_ILL;
          endcase
        end
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t           state_r, state_n;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] opb_r, hi_r, lo_r;

  logic [3:0]       ctl_s;
  logic             multi_s, last_s;
  logic [WIDTH-1:0] sum_s, diff_s, sc_res_s, step_hi_s, step_lo_s;
  logic             sc_ovf_s, sc_ill_s;
  logic [WIDTH:0]   mul_sum_s, shifted_s, trial_s;

  // Decode, single-cycle ALU, one multiply/divide iteration and next state.
  always_comb begin
    ctl_s    = decode(alu_op, funct);
    multi_s  = (ctl_s == C_MUL) || (ctl_s == C_DIVU);
    last_s   = (state_r == RUN) && (cnt_r == CW'(1));
    sum_s    = a + b;
    diff_s   = a - b;
    sc_res_s = {WIDTH{1'b0}};
    sc_ovf_s = 1'b0;
    sc_ill_s = 1'b0;
    case (ctl_s)
      C_ADD: begin
        sc_res_s = sum_s;
        sc_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      C_SUB: begin
        sc_res_s = diff_s;
        sc_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      C_AND:   sc_res_s = a & b;
      C_OR:    sc_res_s = a | b;
      C_SLT:   sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLL:   sc_res_s = a << b[SHW-1:0];
      C_SRL:   sc_res_s = a >> b[SHW-1:0];
      C_MUL:   sc_res_s = {WIDTH{1'b0}};
      C_DIVU:  sc_res_s = {WIDTH{1'b0}};
      default: sc_ill_s = 1'b1;
    endcase

    // Multiply: hi:lo shifts right with carry; divide: remainder in hi, quotient shifts into lo.
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    shifted_s = {hi_r, lo_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, opb_r};
    if (op_r == C_MUL) begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end else if (trial_s[WIDTH]) begin
      step_hi_s = shifted_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
    end else begin
      step_hi_s = trial_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
    end

    state_n = state_r;
    case (state_r)
      IDLE:    state_n = (start && multi_s) ? RUN : IDLE;
      RUN:     state_n = last_s ? IDLE : RUN;
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_n;
  end

  // Operand latches, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0; op_r <= 4'd0; opb_r <= '0; hi_r <= '0; lo_r <= '0;
      result <= '0; result_hi <= '0; alu_ctl <= 4'd0; zero <= 1'b0;
      ovf <= 1'b0; div_zero <= 1'b0; illegal <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && multi_s) begin
            op_r  <= ctl_s;
            opb_r <= b;
            hi_r  <= '0;
            lo_r  <= a;
            cnt_r <= CW'(WIDTH);
            busy  <= 1'b1;
          end else if (start) begin
            result    <= sc_res_s;
            result_hi <= '0;
            alu_ctl   <= ctl_s;
            zero      <= (sc_res_s == {WIDTH{1'b0}});
            ovf       <= sc_ovf_s;
            div_zero  <= 1'b0;
            illegal   <= sc_ill_s;
            done      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r - CW'(1);
          if (last_s) begin
            result    <= step_lo_s;
            result_hi <= step_hi_s;
            alu_ctl   <= op_r;
            zero      <= (step_lo_s == {WIDTH{1'b0}});
            ovf       <= 1'b0;
            div_zero  <= (op_r == C_DIVU) && (opb_r == {WIDTH{1'b0}});
            illegal   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Scoreboard bench for alu_ctl_seq: expectations queued at start, popped and compared at done.
module tb_alu_ctl_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset, start;
  logic [1:0] alu_op;
  logic [3:0] funct;
  logic [W-1:0] a, b, result, result_hi;
  logic [3:0] alu_ctl;
  logic zero, ovf, div_zero, illegal, busy, done;

  typedef struct packed {
    logic [3:0]   ctl;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic z, o, dz, il;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_ctl_seq #(.WIDTH(W), .FUNCT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .result(result), .result_hi(result_hi), .alu_ctl(alu_ctl),
    .zero(zero), .ovf(ovf), .div_zero(div_zero), .illegal(illegal),
    .busy(busy), .done(done)
  );

  function automatic exp_t obs();
    return {alu_ctl, result, result_hi, zero, ovf, div_zero, illegal};
  endfunction

  function automatic exp_t mk(input logic [3:0] c, input logic [W-1:0] r, input logic [W-1:0] h,
                              input logic z, input logic o, input logic d, input logic i);
    return {c, r, h, z, o, d, i};
  endfunction

  // Behavioural reference using native operators.
  function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    e = '0;
    case (op)
      2'b00: e.ctl = 4'd0;
      2'b01: e.ctl = 4'd1;
      2'b11: e.ctl = 4'd4;
      default: e.ctl = (fn <= 4'd6 || fn == 4'd8 || fn == 4'd9) ? fn : 4'd15;
    endcase
    case (e.ctl)
      4'd0: begin e.res = x + y; e.o = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]); end
      4'd1: begin e.res = x - y; e.o = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]); end
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      4'd5: e.res = x << y[3:0];
      4'd6: e.res = x >> y[3:0];
      4'd8: begin p = {16'd0, x} * {16'd0, y}; e.res = p[W-1:0]; e.hi = p[2*W-1:W]; end
      4'd9: begin
        if (y == 16'd0) begin e.res = 16'hFFFF; e.hi = x; e.dz = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; end
      end
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    alu_op = op; funct = fn; a = x; b = y; start = 1'b1;
  endtask

  // Waits for done; scrambles operands after acceptance and optionally pulses a stray start.
  task automatic wait_done(input int budget, input int inject_at, output int cyc, output int bcnt);
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject_at);
      if (cyc == inject_at) alu_op = 2'b00;
      a = 16'($urandom); b = 16'($urandom);
      if (busy) bcnt++;
    end while (!done && cyc < budget);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({obs(), busy, done} !== '0) $display("FAIL reset_state: got %h busy %b done %b want 0", obs(), busy, done);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_add_ovf();
    int cyc, bc; exp_t e;
    drive(2'b00, 4'h0, 16'h7FFF, 16'h0001);
    sb.push_back(mk(4'd0, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 1 || obs() !== e) $display("FAIL add_ovf: lat %0d got %h want lat 1 %h", cyc, obs(), e);
    else n_pass++;
  endtask

  task automatic test_slt_back_to_back();
    int cyc, bc; exp_t e;
    drive(2'b10, 4'h4, 16'hFFFF, 16'h0001);
    sb.push_back(mk(4'd4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 1 || obs() !== e) $display("FAIL slt_rtype: lat %0d got %h want lat 1 %h", cyc, obs(), e);
    else n_pass++;
    drive(2'b11, 4'h0, 16'h0001, 16'hFFFF);
    sb.push_back(mk(4'd4, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 1 || obs() !== e) $display("FAIL slti_b2b: lat %0d got %h want lat 1 %h", cyc, obs(), e);
    else n_pass++;
  endtask

  task automatic test_mul();
    int cyc, bc, nd; exp_t e;
    drive(2'b10, 4'h8, 16'h1234, 16'h0010);
    sb.push_back(mk(4'd8, 16'h2340, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_done(40, 5, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 17 || obs() !== e) $display("FAIL mul: lat %0d got %h want lat 17 %h", cyc, obs(), e);
    else n_pass++;
    n_total++;
    if (bc !== 16) $display("FAIL mul_busy: busy cycles %0d want 16", bc);
    else n_pass++;
    nd = 0;
    repeat (20) begin @(negedge clk); if (done) nd++; end
    n_total++;
    if (nd !== 0 || obs() !== e) $display("FAIL mul_ignored_start: extra done %0d got %h want 0 %h", nd, obs(), e);
    else n_pass++;
  endtask

  task automatic test_divu();
    int cyc, bc; exp_t e;
    drive(2'b10, 4'h9, 16'd100, 16'd7);
    sb.push_back(mk(4'd9, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 17 || obs() !== e) $display("FAIL divu: lat %0d got %h want lat 17 %h", cyc, obs(), e);
    else n_pass++;
    drive(2'b10, 4'h9, 16'd100, 16'd0);
    sb.push_back(mk(4'd9, 16'hFFFF, 16'h0064, 1'b0, 1'b0, 1'b1, 1'b0));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 17 || obs() !== e) $display("FAIL divu_zero: lat %0d got %h want lat 17 %h", cyc, obs(), e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc, nd; exp_t e;
    drive(2'b10, 4'h8, 16'hABCD, 16'h1234);
    repeat (4) begin @(negedge clk); start = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({obs(), busy, done} !== '0) $display("FAIL reset_mid_op: got %h busy %b done %b want 0", obs(), busy, done);
    else n_pass++;
    nd = 0;
    repeat (24) begin @(negedge clk); if (done) nd++; end
    n_total++;
    if (nd !== 0) $display("FAIL abandoned_done: done pulses %0d want 0", nd);
    else n_pass++;
    drive(2'b00, 4'h0, 16'd2, 16'd3);
    sb.push_back(mk(4'd0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 1 || obs() !== e) $display("FAIL add_after_reset: lat %0d got %h want lat 1 %h", cyc, obs(), e);
    else n_pass++;
  endtask

  task automatic test_illegal_and_reset_start();
    int cyc, bc; exp_t e;
    drive(2'b10, 4'hF, 16'h5555, 16'h0003);
    sb.push_back(mk(4'd15, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
    wait_done(40, 0, cyc, bc); e = sb.pop_front();
    n_total++;
    if (cyc !== 1 || obs() !== e) $display("FAIL illegal: lat %0d got %h want lat 1 %h", cyc, obs(), e);
    else n_pass++;
    reset = 1'b1;
    drive(2'b00, 4'h0, 16'd2, 16'd3);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_total++;
    if ({obs(), busy, done} !== '0) $display("FAIL reset_with_start: got %h busy %b done %b want 0", obs(), busy, done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL reset_with_start_late: done %b want 0", done);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random_back_to_back();
    int cyc, bc, lat; exp_t e;
    logic [1:0] op; logic [3:0] fn; logic [W-1:0] x, y;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3)); fn = 4'($urandom_range(0, 15));
      x = pick(); y = pick();
      drive(op, fn, x, y);
      sb.push_back(model(op, fn, x, y));
      lat = (sb[sb.size()-1].ctl == 4'd8 || sb[sb.size()-1].ctl == 4'd9) ? 17 : 1;
      wait_done(40, 0, cyc, bc); e = sb.pop_front();
      n_total++;
      if (cyc !== lat || obs() !== e)
        $display("FAIL rand_%0d op %b fn %h a %h b %h: lat %0d got %h want lat %0d %h", i, op, fn, x, y, cyc, obs(), lat, e);
      else n_pass++;
    end
  endtask

  initial begin
    start = 1'b0; alu_op = 2'b00; funct = 4'h0; a = '0; b = '0; reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_ovf();
    test_slt_back_to_back();
    test_mul();
    test_divu();
    test_reset_mid_op();
    test_illegal_and_reset_start();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
